// File: rtl/delay_measure_ctrl.sv
// delay_measure_ctrl: sequences alternating-edge launches into a path under
// test, timestamps each launch and arrival from the free-running datapath
// counter, and accumulates last/sum/min/max propagation delay in cycles.
//
// Handshake: start is a one-cycle request taken only in IDLE (it is ignored
// and not queued otherwise); busy rises the cycle after start is accepted and
// falls the cycle after the single-cycle done pulse; results stay stable from
// done until the next accepted start.
module delay_measure_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_TRIALS  = 16,
  parameter int SETTLE      = 64,
  parameter int TIMEOUT     = 1024,
  parameter bit INVERT      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] count_in,
  input  logic        path_result,
  output logic        path_input,
  output logic        count_ld,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [7:0]  trial_idx,
  output logic [31:0] last_delay,
  output logic [39:0] sum_delay,
  output logic [31:0] min_delay,
  output logic [31:0] max_delay,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   path_input_q;
  logic                   count_ld_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   timeout_err_q;
  logic [7:0]             trial_idx_q;
  logic [31:0]            last_delay_q;
  logic [39:0]            sum_delay_q;
  logic [31:0]            min_delay_q;
  logic [31:0]            max_delay_q;
  logic [31:0]            settle_cnt_q;
  logic [31:0]            wait_cnt_q;
  logic [31:0]            t0_q;
  logic                   wait_first_q;

  logic        rs;
  logic        arrive_d;
  logic [31:0] t0_d;
  logic [31:0] elapsed_d;
  logic [31:0] delay_d;

  // Bring the asynchronous path output into the clock domain; only the last
  // stage is ever looked at.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], path_result};
  end

  assign rs = sync_q[SYNC_STAGES-1];

  // Delay of the current trial: modular counter difference minus the
  // synchroniser latency, clamped at zero. The launch timestamp is taken in
  // the first WAIT cycle, so that cycle uses count_in directly.
  always_comb begin
    arrive_d  = (rs == (path_input_q ^ INVERT));
    t0_d      = wait_first_q ? count_in : t0_q;
    elapsed_d = count_in - t0_d;
    delay_d   = (elapsed_d < 32'(SYNC_STAGES)) ? 32'd0
                                               : elapsed_d - 32'(SYNC_STAGES);
  end

  // Measurement sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      path_input_q  <= 1'b0;
      count_ld_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      trial_idx_q   <= 8'd0;
      last_delay_q  <= 32'd0;
      sum_delay_q   <= 40'd0;
      min_delay_q   <= 32'hFFFF_FFFF;
      max_delay_q   <= 32'd0;
      settle_cnt_q  <= 32'd0;
      wait_cnt_q    <= 32'd0;
      t0_q          <= 32'd0;
      wait_first_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            timeout_err_q <= 1'b0;
            trial_idx_q   <= 8'd0;
            last_delay_q  <= 32'd0;
            sum_delay_q   <= 40'd0;
            min_delay_q   <= 32'hFFFF_FFFF;
            max_delay_q   <= 32'd0;
            busy_q        <= 1'b1;
            count_ld_q    <= 1'b1;
            settle_cnt_q  <= 32'd0;
            state_q       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_q == 32'(SETTLE - 1)) state_q <= S_LAUNCH;
          else                                 settle_cnt_q <= settle_cnt_q + 32'd1;
        end
        S_LAUNCH: begin
          path_input_q <= ~path_input_q;
          wait_first_q <= 1'b1;
          wait_cnt_q   <= 32'd0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          wait_first_q <= 1'b0;
          t0_q         <= t0_d;
          wait_cnt_q   <= wait_cnt_q + 32'd1;
          if (arrive_d) begin
            last_delay_q <= delay_d;
            sum_delay_q  <= sum_delay_q + {8'd0, delay_d};
            if (delay_d < min_delay_q) min_delay_q <= delay_d;
            if (delay_d > max_delay_q) max_delay_q <= delay_d;
            trial_idx_q  <= trial_idx_q + 8'd1;
            if (trial_idx_q == 8'(NUM_TRIALS - 1)) begin
              done_q     <= 1'b1;
              count_ld_q <= 1'b0;
              state_q    <= S_DONE;
            end else begin
              settle_cnt_q <= 32'd0;
              state_q      <= S_SETTLE;
            end
          end else if (wait_cnt_q == 32'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            done_q        <= 1'b1;
            count_ld_q    <= 1'b0;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign path_input  = path_input_q;
  assign count_ld    = count_ld_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign trial_idx   = trial_idx_q;
  assign last_delay  = last_delay_q;
  assign sum_delay   = sum_delay_q;
  assign min_delay   = min_delay_q;
  assign max_delay   = max_delay_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_delay_measure_ctrl.sv
// Bench for delay_measure_ctrl: two instances (non-inverting and inverting
// path), each with a free-running counter model and a path model that delays
// path_input by a per-trial number of cycles.
module tb_delay_measure_ctrl;

  localparam int SYNC   = 2;
  localparam int NTR    = 4;
  localparam int SETTLE = 12;
  localparam int TO0    = 16;
  localparam int TO1    = 64;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // per-lane DUT signals
  logic        start_s [2];
  logic [31:0] cnt     [2] = '{32'd0, 32'd0};
  logic        pres    [2];
  logic        pin     [2];
  logic        cld     [2];
  logic        busy    [2];
  logic        done    [2];
  logic        terr    [2];
  logic [7:0]  tidx    [2];
  logic [31:0] last    [2];
  logic [39:0] sum     [2];
  logic [31:0] mind    [2];
  logic [31:0] maxd    [2];
  logic [2:0]  st      [2];

  // environment models
  logic        pre_req [2] = '{1'b0, 1'b0};
  logic [31:0] pre_val [2] = '{32'd0, 32'd0};
  int          tog     [2] = '{0, 0};
  logic        pprev   [2] = '{1'b0, 1'b0};
  logic [31:0] hist    [2] = '{32'd0, 32'd0};
  int          dtab    [2][16];
  bit          stuck   [2] = '{1'b0, 1'b0};
  int          d_idx   [2];
  int          d_cur   [2];

  // scoreboard
  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  logic [39:0] e_sum;
  logic [31:0] e_min, e_max, e_last;
  int n_checks = 0;
  int n_pass   = 0;

  delay_measure_ctrl #(.SYNC_STAGES(SYNC), .NUM_TRIALS(NTR), .SETTLE(SETTLE),
                       .TIMEOUT(TO0), .INVERT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .count_in(cnt[0]),
    .path_result(pres[0]), .path_input(pin[0]), .count_ld(cld[0]),
    .busy(busy[0]), .done(done[0]), .timeout_err(terr[0]), .trial_idx(tidx[0]),
    .last_delay(last[0]), .sum_delay(sum[0]), .min_delay(mind[0]),
    .max_delay(maxd[0]), .state_dbg(st[0]));

  delay_measure_ctrl #(.SYNC_STAGES(SYNC), .NUM_TRIALS(NTR), .SETTLE(SETTLE),
                       .TIMEOUT(TO1), .INVERT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .count_in(cnt[1]),
    .path_result(pres[1]), .path_input(pin[1]), .count_ld(cld[1]),
    .busy(busy[1]), .done(done[1]), .timeout_err(terr[1]), .trial_idx(tidx[1]),
    .last_delay(last[1]), .sum_delay(sum[1]), .min_delay(mind[1]),
    .max_delay(maxd[1]), .state_dbg(st[1]));

  // Counter advances whenever count_ld is high; launch count selects the
  // delay of the trial in flight.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      hist[l] <= {hist[l][30:0], pin[l]};
      if (pre_req[l]) begin
        cnt[l]   <= pre_val[l];
        tog[l]   <= 0;
        pprev[l] <= pin[l];
      end else begin
        if (cld[l] === 1'b1) cnt[l] <= cnt[l] + 32'd1;
        if (pin[l] !== pprev[l]) tog[l] <= tog[l] + 1;
        pprev[l] <= pin[l];
      end
    end
  end

  // Path output is path_input seen d cycles later (inverted on lane 1).
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      d_idx[l] = (tog[l] > 16) ? 15 : ((tog[l] > 0) ? tog[l] - 1 : 0);
      d_cur[l] = dtab[l][d_idx[l]];
      pres[l]  = stuck[l] ? 1'b0 : (hist[l][5'(d_cur[l] - 1)] ^ (l == 1));
    end
  end

  // reference model: each trial measures exactly the path delay in cycles
  function automatic void build_expect(input int l);
    exp_q.delete();
    e_sum = 40'd0; e_min = 32'hFFFF_FFFF; e_max = 32'd0; e_last = 32'd0;
    for (int i = 0; i < NTR; i++) begin
      exp_q.push_back(32'(dtab[l][i]));
      e_sum  = e_sum + 40'(dtab[l][i]);
      if (32'(dtab[l][i]) < e_min) e_min = 32'(dtab[l][i]);
      if (32'(dtab[l][i]) > e_max) e_max = 32'(dtab[l][i]);
      e_last = 32'(dtab[l][i]);
    end
  endfunction

  // driver: one measurement run, collecting per-trial results and done pulses
  task automatic run_lane(input int l, input logic [31:0] preset, input bit poke,
                          output int n_done, output int w0_cyc, output int done_cyc,
                          output bit over);
    logic [7:0] pidx;
    logic       ppin;
    int         nl, since;
    bit         poked;
    obs_q.delete();
    n_done = 0; w0_cyc = -1; done_cyc = -1; over = 1'b1;
    nl = 0; since = 0; poked = 1'b0;
    @(negedge clk);
    pre_val[l] = preset; pre_req[l] = 1'b1; start_s[l] = 1'b1;
    @(negedge clk);
    pre_req[l] = 1'b0; start_s[l] = 1'b0;
    pidx = tidx[l]; ppin = pin[l];
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start_s[l] = 1'b0;
      if (pin[l] !== ppin) begin
        nl++; since = 0;
        if (w0_cyc < 0) w0_cyc = c;
      end else since++;
      ppin = pin[l];
      if (tidx[l] !== pidx) begin obs_q.push_back(last[l]); pidx = tidx[l]; end
      if (poke && !poked && nl == 2 && since == 2) begin start_s[l] = 1'b1; poked = 1'b1; end
      if (done[l] === 1'b1) begin n_done++; done_cyc = c; end
      if (n_done > 0 && busy[l] === 1'b0) begin over = 1'b0; break; end
    end
    start_s[l] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done[l] === 1'b1) n_done++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      n_checks++; if ({pin[l], cld[l], busy[l], done[l], terr[l]} !== 5'b0)
        $display("FAIL reset_flags lane%0d: got %b expected 00000", l, {pin[l], cld[l], busy[l], done[l], terr[l]}); else n_pass++;
      n_checks++; if (tidx[l] !== 8'd0 || last[l] !== 32'd0 || sum[l] !== 40'd0)
        $display("FAIL reset_stats lane%0d: got idx=%0d last=%0d sum=%0d expected 0/0/0", l, tidx[l], last[l], sum[l]); else n_pass++;
      n_checks++; if (mind[l] !== 32'hFFFF_FFFF || maxd[l] !== 32'd0)
        $display("FAIL reset_minmax lane%0d: got min=%h max=%h expected ffffffff/0", l, mind[l], maxd[l]); else n_pass++;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int nd, w0, dc; bit ov;
    for (int i = 0; i < 16; i++) dtab[0][i] = 5;
    build_expect(0);
    run_lane(0, 32'd0, 1'b0, nd, w0, dc, ov);
    n_checks++; if (ov) $display("FAIL basic_budget: run did not finish"); else n_pass++;
    n_checks++; if (nd != 1) $display("FAIL basic_done: got %0d pulses expected 1", nd); else n_pass++;
    n_checks++; if (obs_q.size() != NTR) $display("FAIL basic_ntrials: got %0d expected %0d", obs_q.size(), NTR); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL basic_trial%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (last[0] !== e_last || mind[0] !== e_min || maxd[0] !== e_max)
      $display("FAIL basic_lmm: got %0d/%0d/%0d expected %0d/%0d/%0d", last[0], mind[0], maxd[0], e_last, e_min, e_max); else n_pass++;
    n_checks++; if (sum[0] !== e_sum) $display("FAIL basic_sum: got %0d expected %0d", sum[0], e_sum); else n_pass++;
    n_checks++; if (terr[0] !== 1'b0 || pin[0] !== 1'b0 || busy[0] !== 1'b0 || cld[0] !== 1'b0)
      $display("FAIL basic_end: got terr=%b pin=%b busy=%b ld=%b expected 0000", terr[0], pin[0], busy[0], cld[0]); else n_pass++;
  endtask

  task automatic test_alternating;
    int nd, w0, dc; bit ov;
    for (int i = 0; i < 16; i++) dtab[0][i] = (i % 2 == 0) ? 3 : 7;
    build_expect(0);
    run_lane(0, 32'd1000, 1'b0, nd, w0, dc, ov);
    n_checks++; if (ov || nd != 1) $display("FAIL alt_done: got over=%0d pulses=%0d expected 0/1", ov, nd); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL alt_trial%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (mind[0] !== 32'd3 || maxd[0] !== 32'd7)
      $display("FAIL alt_minmax: got %0d/%0d expected 3/7", mind[0], maxd[0]); else n_pass++;
    n_checks++; if (sum[0] !== 40'd20 || tidx[0] !== 8'd4)
      $display("FAIL alt_sum_idx: got %0d/%0d expected 20/4", sum[0], tidx[0]); else n_pass++;
  endtask

  task automatic test_wrap;
    int nd, w0, dc; bit ov;
    for (int i = 0; i < 16; i++) dtab[0][i] = 7;
    build_expect(0);
    // first launch timestamp lands on 32'hFFFFFFFE
    run_lane(0, 32'hFFFF_FFFE - 32'(SETTLE + 1), 1'b0, nd, w0, dc, ov);
    n_checks++; if (obs_q.size() < 1 || obs_q[0] !== 32'd7)
      $display("FAIL wrap_first: got %0d expected 7", (obs_q.size() > 0) ? obs_q[0] : 32'hDEAD); else n_pass++;
    n_checks++; if (last[0] !== 32'd7 || sum[0] !== e_sum)
      $display("FAIL wrap_stats: got last=%0d sum=%0d expected 7/%0d", last[0], sum[0], e_sum); else n_pass++;
  endtask

  task automatic test_timeout;
    int nd, w0, dc; bit ov;
    stuck[0] = 1'b1;
    run_lane(0, 32'd0, 1'b0, nd, w0, dc, ov);
    stuck[0] = 1'b0;
    n_checks++; if (ov || nd != 1) $display("FAIL to_done: got over=%0d pulses=%0d expected 0/1", ov, nd); else n_pass++;
    n_checks++; if (dc - w0 != TO0) $display("FAIL to_latency: got %0d expected %0d", dc - w0, TO0); else n_pass++;
    n_checks++; if (terr[0] !== 1'b1) $display("FAIL to_err: got %b expected 1", terr[0]); else n_pass++;
    n_checks++; if (sum[0] !== 40'd0 || mind[0] !== 32'hFFFF_FFFF || tidx[0] !== 8'd0)
      $display("FAIL to_stats: got sum=%0d min=%h idx=%0d expected 0/ffffffff/0", sum[0], mind[0], tidx[0]); else n_pass++;
  endtask

  task automatic test_random;
    int nd, w0, dc; bit ov;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) dtab[0][i] = int'($urandom_range(13, 1));
      build_expect(0);
      run_lane(0, $urandom, 1'b0, nd, w0, dc, ov);
      n_checks++; if (ov || nd != 1 || terr[0] !== 1'b0)
        $display("FAIL rnd%0d_done: got over=%0d pulses=%0d terr=%b expected 0/1/0", r, ov, nd, terr[0]); else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rnd%0d_trial%0d: got %0d expected %0d", r, i, obs_q[i], exp_q[i]); else n_pass++;
      end
      n_checks++; if (sum[0] !== e_sum || mind[0] !== e_min || maxd[0] !== e_max || tidx[0] !== 8'(NTR))
        $display("FAIL rnd%0d_stats: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", r, sum[0], mind[0], maxd[0], tidx[0], e_sum, e_min, e_max, NTR); else n_pass++;
    end
  endtask

  task automatic test_invert_start_ignored;
    int nd, w0, dc; bit ov;
    for (int i = 0; i < 16; i++) dtab[1][i] = 4;
    build_expect(1);
    run_lane(1, 32'd77, 1'b1, nd, w0, dc, ov);
    n_checks++; if (ov || nd != 1) $display("FAIL inv_done: got over=%0d pulses=%0d expected 0/1", ov, nd); else n_pass++;
    n_checks++; if (obs_q.size() != NTR) $display("FAIL inv_ntrials: got %0d expected %0d", obs_q.size(), NTR); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL inv_trial%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (sum[1] !== 40'd16 || tidx[1] !== 8'd4 || busy[1] !== 1'b0)
      $display("FAIL inv_end: got sum=%0d idx=%0d busy=%b expected 16/4/0", sum[1], tidx[1], busy[1]); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int nd, w0, dc, nl; bit ov; logic ppin;
    for (int i = 0; i < 16; i++) dtab[0][i] = 5;
    @(negedge clk);
    pre_val[0] = 32'd0; pre_req[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    pre_req[0] = 1'b0; start_s[0] = 1'b0;
    ppin = pin[0]; nl = 0;
    for (int c = 0; c < 500 && nl < 2; c++) begin
      @(negedge clk);
      if (pin[0] !== ppin) nl++;
      ppin = pin[0];
    end
    n_checks++; if (nl != 2) $display("FAIL mid_launch: got %0d launches expected 2", nl); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (tidx[0] !== 8'd1 || last[0] !== 32'd5)
      $display("FAIL mid_pre: got idx=%0d last=%0d expected 1/5", tidx[0], last[0]); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({pin[0], cld[0], busy[0], done[0], terr[0]} !== 5'b0)
      $display("FAIL mid_rst_flags: got %b expected 00000", {pin[0], cld[0], busy[0], done[0], terr[0]}); else n_pass++;
    n_checks++; if (tidx[0] !== 8'd0 || last[0] !== 32'd0 || sum[0] !== 40'd0 || mind[0] !== 32'hFFFF_FFFF || maxd[0] !== 32'd0)
      $display("FAIL mid_rst_stats: got %0d/%0d/%0d/%h/%0d expected 0/0/0/ffffffff/0", tidx[0], last[0], sum[0], mind[0], maxd[0]); else n_pass++;
    rst_n = 1'b1;
    repeat (SETTLE + 4) @(negedge clk);
    n_checks++; if (busy[0] !== 1'b0 || cld[0] !== 1'b0)
      $display("FAIL mid_stays_idle: got busy=%b ld=%b expected 0/0", busy[0], cld[0]); else n_pass++;
    build_expect(0);
    run_lane(0, 32'd5, 1'b0, nd, w0, dc, ov);
    n_checks++; if (ov || nd != 1 || sum[0] !== e_sum || tidx[0] !== 8'(NTR) || mind[0] !== e_min || maxd[0] !== e_max)
      $display("FAIL mid_rerun: got over=%0d pulses=%0d sum=%0d idx=%0d min=%0d max=%0d expected 0/1/%0d/%0d/%0d/%0d",
               ov, nd, sum[0], tidx[0], mind[0], maxd[0], e_sum, NTR, e_min, e_max); else n_pass++;
  endtask

  initial begin
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    for (int l = 0; l < 2; l++) for (int i = 0; i < 16; i++) dtab[l][i] = 1;
    test_reset;
    test_basic;
    test_alternating;
    test_wrap;
    test_timeout;
    test_random;
    test_invert_start_ignored;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/delay_measure_ctrl.md
Name: delay_measure_ctrl

Overview:
- Sequencing controller that sits directly upstream of the delay datapath.
- Drives the path-under-test input and the cycle-counter load enable, and watches the path output.
- Runs NUM_TRIALS alternating-edge launches and reports per-trial, sum, min and max propagation delay in clock cycles.
- It never resets the datapath counter; each delay is a modular difference of counter snapshots.

Parameters:
- SYNC_STAGES, 2, flops in the path_result synchroniser (2..4).
- NUM_TRIALS, 16, launches per measurement run (1..255).
- SETTLE, 64, idle cycles before each launch (>=SYNC_STAGES+1).
- TIMEOUT, 1024, max cycles waited per trial before abort.
- INVERT, 0, 1 when the path under test is inverting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a run; ignored while busy
- count_in  in  32  datapath counter value (result)
- path_result  in  1  asynchronous path output (pathResult)
- path_input  out  1  launch signal to path under test (pathInput)
- count_ld  out  1  datapath counter load/increment enable (ld)
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of run
- timeout_err  out  1  set when a trial timed out; held until next start
- trial_idx  out  8  index of the current or last trial
- last_delay  out  32  delay of most recent completed trial
- sum_delay  out  40  sum of trial delays
- min_delay  out  32  minimum trial delay
- max_delay  out  32  maximum trial delay

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, path_input=0, count_ld=0, busy=0, done=0, timeout_err=0, trial_idx=0, last_delay=0, sum_delay=0, min_delay=32'hFFFFFFFF, max_delay=0, synchroniser cleared to 0.
  - Reset mid-run aborts immediately.
  - Reset has priority over every other event.
- path_result passes through SYNC_STAGES flops; only the last stage (rs) is used. expected = path_input ^ INVERT.
- count_ld = 1 in every state except IDLE and DONE. The counter therefore advances once per cycle throughout a run.
- State IDLE: on start=1, the following all happen in the same cycle, then the FSM goes to SETTLE:
  - clear outputs (as at reset, except path_input, which keeps its value);
  - busy=1 next cycle.
- State SETTLE: count SETTLE cycles with path_input stable, then go to LAUNCH.
- State LAUNCH (1 cycle): path_input <= ~path_input; then go to WAIT.
  - t0 <= count_in sampled in the first cycle path_input holds the new value, i.e. the first WAIT cycle.
- State WAIT: each cycle compare rs to expected and increment wait_cnt.
  - Arrival (rs == expected):
    - delay = (count_in - t0 - SYNC_STAGES) mod 2^32, saturating to 0 if count_in - t0 < SYNC_STAGES;
    - last_delay <= delay; sum_delay += delay (zero-extended);
    - min/max update (compare includes equality; no change on equal);
    - trial_idx += 1;
    - go to DONE if trial_idx+1 == NUM_TRIALS, else go to SETTLE.
  - Counter wrap is handled by the modular subtraction. Example: t0=32'hFFFFFFFE, count_in=32'h00000005, SYNC_STAGES=2 gives delay=5.
  - Timeout: if wait_cnt reaches TIMEOUT with no arrival, timeout_err <= 1 and go to DONE. Statistics keep the values of completed trials.
  - Arrival and timeout in the same cycle: arrival wins.
- State DONE: done=1 for exactly one cycle, busy <= 0, then go to IDLE. All results are held until the next start.
- Trials alternate rising and falling launch edges because path_input toggles. path_input is not returned to 0 between runs.
- start asserted during any non-IDLE state is ignored and not queued.

Test Plan:
- Non-inverting path model with a 5-cycle delay, NUM_TRIALS=4, SYNC_STAGES=2, counter model incrementing on count_ld → last_delay=min=max=5, sum_delay=20, one done pulse, timeout_err=0, path_input ends at 0 after 4 toggles.
- Model delays alternating 3 and 7 cycles, NUM_TRIALS=4 → min_delay=3, max_delay=7, sum_delay=20, trial_idx=4.
- Counter preset so t0=32'hFFFFFFFE, delay 7 → last_delay=7 despite wrap.
- Path stuck at 0, TIMEOUT=16 → done pulses 16 cycles after the first WAIT cycle, timeout_err=1, sum_delay=0, min_delay=32'hFFFFFFFF.
- INVERT=1 with an inverting 4-cycle model → delay=4 on every trial. Separately, start pulsed during WAIT → no effect on trial count.
- rst_n=0 during WAIT of trial 2 → next cycle all outputs at reset values and count_ld=0. A later start runs a clean full measurement.
